// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry skid pipeline stage with flush and stall counter
//
// Ports:
//   clk        clock, all state updates on its rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat this cycle (registered decode)
//   in_data    upstream payload
//   flush      synchronous kill of all held beats
//   out_valid  out_data holds a valid beat
//   out_ready  downstream accepts the beat this cycle
//   out_data   payload presented downstream
//   occupancy  number of beats held (0, 1 or 2)
//   stall_cnt  saturating count of cycles with in_valid=1 and in_ready=0

module pipe_skid_stage #(
  parameter int DATA_W = 104,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_q;
  logic              in_fire;
  logic              out_fire;

  // Handshake outputs decode only the registered state, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      // Stall accounting runs independently of flush.
      if (in_valid && !in_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end

      // Flush drops validity only; payload registers keep their contents.
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q <= in_data;
              state  <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_q <= in_data;
            end else if (in_fire) begin
              skid_q <= in_data;
              state  <= FULL;
            end else if (out_fire) begin
              state  <= EMPTY;
            end
          end
          FULL: begin
            // in_ready is low here, so only the drain path can move.
            if (out_fire) begin
              main_q <= skid_q;
              state  <= ONE;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule
